// File: rtl/epd_hdr_capture_pkg.sv
// ============================================================================
// Module      : epd_pkg
// Description : Shared types and constants for the Ethernet header capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package epd_pkg;

  localparam int EPD_MAC_W     = 48;
  localparam int EPD_TL_W      = 16;
  localparam int EPD_MAC_BYTES = 6;
  localparam int EPD_TL_BYTES  = 2;
  localparam int EPD_HDR_W     = 112;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DST   = 3'd1,
    SRC   = 3'd2,
    TL    = 3'd3,
    WAIT  = 3'd4,
    ABORT = 3'd5
  } epd_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/epd_hdr_capture_if.sv
// ============================================================================
// Module      : epd_hdr_capture_if
// Description : Detector byte stream, field pulses and header record handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface epd_hdr_capture_if;
  import epd_pkg::*;

  logic [7:0]           data;
  logic                 control;
  logic                 preamble_valid;
  logic                 dst_addr_valid;
  logic                 src_addr_valid;
  logic                 type_length_valid;
  logic                 packet_size_valid;
  logic                 hdr_valid;
  logic                 hdr_ready;
  logic [EPD_MAC_W-1:0] hdr_dst;
  logic [EPD_MAC_W-1:0] hdr_src;
  logic [EPD_TL_W-1:0]  hdr_type_length;

  modport master (
    output data, control, preamble_valid, dst_addr_valid, src_addr_valid,
           type_length_valid, packet_size_valid, hdr_ready,
    input  hdr_valid, hdr_dst, hdr_src, hdr_type_length
  );

  modport slave (
    input  data, control, preamble_valid, dst_addr_valid, src_addr_valid,
           type_length_valid, packet_size_valid, hdr_ready,
    output hdr_valid, hdr_dst, hdr_src, hdr_type_length
  );

endinterface

`default_nettype wire

// File: rtl/epd_hdr_capture_fifo.sv
// ============================================================================
// Module      : epd_hdr_fifo
// Description : Header record FIFO with registered head; EPD_HDR_STATS_EN adds
//               a saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module epd_hdr_fifo
  import epd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = EPD_HDR_W
) (
  input  wire logic             clock,
  input  wire logic             reset_n,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_din,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_head,
  output logic                  o_empty
`ifdef EPD_HDR_STATS_EN
  ,
  output logic      [7:0]       o_drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [WIDTH-1:0] r_head;
  logic [PW-1:0]    w_rd_nxt;
  logic             w_full;
  logic             w_pop;
  logic             w_wr_en;

  assign o_empty  = (r_wr == r_rd);
  assign w_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop    = i_pop & ~o_empty;
  // A pop on the same edge frees the slot, so a push at full still lands.
  assign w_wr_en  = i_push & (~w_full | w_pop);
  assign w_rd_nxt = r_rd + {{AW{1'b0}}, w_pop};
  assign o_head   = r_head;

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[r_wr[AW-1:0]] <= i_din;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_head <= '0;
    end else begin
      r_wr <= r_wr + {{AW{1'b0}}, w_wr_en};
      r_rd <= w_rd_nxt;
      // The incoming record becomes the head when it lands at the new read slot.
      if (w_wr_en && (r_wr == w_rd_nxt)) begin
        r_head <= i_din;
      end else if (w_pop) begin
        r_head <= r_mem[w_rd_nxt[AW-1:0]];
      end
    end
  end

`ifdef EPD_HDR_STATS_EN
  logic [7:0] r_drop_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_count <= 8'd0;
    end else if (i_push && !w_wr_en) begin
      r_drop_count <= sat_inc8(r_drop_count);
    end
  end

  assign o_drop_count = r_drop_count;
`endif

endmodule

`default_nettype wire

// File: rtl/epd_hdr_capture.sv
// ============================================================================
// Module      : epd_hdr_capture
// Description : Captures DST/SRC/TL fields of detected frames into a FIFO;
//               EPD_HDR_STATS_EN adds abort_count and drop_count outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module epd_hdr_capture
  import epd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic        clock,
  input  wire logic        reset_n,
  epd_hdr_capture_if.slave hif
`ifdef EPD_HDR_STATS_EN
  ,
  output logic [7:0]       abort_count,
  output logic [7:0]       drop_count
`endif
);

  epd_state_e           r_state, w_state_nxt;
  logic [2:0]           r_cnt, w_cnt_nxt;
  logic [EPD_MAC_W-1:0] r_dst, r_src;
  logic [EPD_TL_W-1:0]  r_tl;
  logic                 w_dst_sh, w_src_sh, w_tl_sh, w_push, w_start;
  logic [EPD_HDR_W-1:0] w_head;
  logic                 w_empty;

  assign w_start = hif.preamble_valid & hif.control;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dst_sh    = 1'b0;
    w_src_sh    = 1'b0;
    w_tl_sh     = 1'b0;
    w_push      = 1'b0;
    // A preamble restarts capture from any state, aborting a frame in flight.
    if (w_start) begin
      w_state_nxt = DST;
      w_cnt_nxt   = 3'd1;
      w_dst_sh    = 1'b1;
    end else begin
      case (r_state)
        IDLE:  w_cnt_nxt = 3'd0;
        DST, SRC: begin
          if (!hif.control) begin
            w_state_nxt = ABORT;
          end else if (r_cnt == 3'(EPD_MAC_BYTES)) begin
            if ((r_state == DST) ? hif.dst_addr_valid : hif.src_addr_valid) begin
              w_state_nxt = (r_state == DST) ? SRC : TL;
              w_cnt_nxt   = 3'd1;
              w_src_sh    = (r_state == DST);
              w_tl_sh     = (r_state == SRC);
            end else begin
              w_state_nxt = ABORT;
            end
          end else if ((r_state == DST) ? hif.dst_addr_valid : hif.src_addr_valid) begin
            w_state_nxt = ABORT;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
            w_dst_sh  = (r_state == DST);
            w_src_sh  = (r_state == SRC);
          end
        end
        TL: begin
          if (!hif.control) begin
            w_state_nxt = ABORT;
          end else if (r_cnt == 3'(EPD_TL_BYTES)) begin
            w_state_nxt = hif.type_length_valid ? WAIT : ABORT;
          end else if (hif.type_length_valid) begin
            w_state_nxt = ABORT;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
            w_tl_sh   = 1'b1;
          end
        end
        WAIT: begin
          if (hif.packet_size_valid) begin
            w_push      = 1'b1;
            w_state_nxt = IDLE;
          end else if (!hif.control) begin
            w_state_nxt = ABORT;
          end
        end
        ABORT:   w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
      if (w_state_nxt == ABORT || w_state_nxt == IDLE) begin
        w_cnt_nxt = 3'd0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_dst   <= '0;
      r_src   <= '0;
      r_tl    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_dst_sh) r_dst <= {r_dst[EPD_MAC_W-9:0], hif.data};
      if (w_src_sh) r_src <= {r_src[EPD_MAC_W-9:0], hif.data};
      if (w_tl_sh)  r_tl  <= {r_tl[EPD_TL_W-9:0], hif.data};
    end
  end

  epd_hdr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EPD_HDR_W)
  ) u_fifo (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_push       (w_push),
    .i_din        ({r_dst, r_src, r_tl}),
    .i_pop        (hif.hdr_ready),
    .o_head       (w_head),
    .o_empty      (w_empty)
`ifdef EPD_HDR_STATS_EN
    ,
    .o_drop_count (drop_count)
`endif
  );

  assign hif.hdr_valid       = ~w_empty;
  assign hif.hdr_dst         = w_head[EPD_HDR_W-1 -: EPD_MAC_W];
  assign hif.hdr_src         = w_head[EPD_TL_W +: EPD_MAC_W];
  assign hif.hdr_type_length = w_head[EPD_TL_W-1:0];

`ifdef EPD_HDR_STATS_EN
  logic [7:0] r_abort_count;
  logic       w_abort_evt;

  // ABORT is left after one cycle, so each entry is seen exactly once here.
  assign w_abort_evt = (w_state_nxt == ABORT) |
                       (w_start & (r_state != IDLE) & (r_state != ABORT));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_abort_count <= 8'd0;
    end else if (w_abort_evt) begin
      r_abort_count <= sat_inc8(r_abort_count);
    end
  end

  assign abort_count = r_abort_count;
`endif

endmodule

`default_nettype wire

// File: doc/epd_hdr_capture.md
# epd_hdr_capture

Downstream consumer of the Ethernet packet detector, `epd_fsm`. It watches the same byte stream and the detector's field-valid pulses, and shifts the DST, SRC and Type/Length fields into shadow registers. When the detector confirms a legal packet size, it commits one 112-bit header record into a small FIFO. Host logic drains the FIFO over a valid/ready handshake.

## Interface
Parameters:
- `DEPTH`, default 4: header FIFO entries; power of two, 2..16.

Ports:
- `clock`  in  1  rising-edge clock, shared with `epd_fsm`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data`  in  8  frame byte stream, same bus as feeds `epd_fsm`.
- `control`  in  1  frame-active qualifier; low means no frame on `data`.
- `preamble_valid`, `dst_addr_valid`, `src_addr_valid`, `type_length_valid`, `packet_size_valid`  in  1 each  single-cycle pulses from `epd_fsm`.
- `hdr_valid`  out  1  FIFO non-empty.
- `hdr_ready`  in  1  consumer accepts the head record.
- `hdr_dst`  out  48  head record DST; first byte received is in [47:40].
- `hdr_src`  out  48  head record SRC; first byte received is in [47:40].
- `hdr_type_length`  out  16  head record Type/Length; first byte received is in [15:8].

## Operation
Input pulse timing:
- Each `*_valid` pulse is sampled high on the same edge on which `data` carries byte 0 of the following field.
- `packet_size_valid` is the exception: it is free-running after TL and marks frame acceptance.

Capture FSM, with byte counter `cnt` (3 bits):
- `IDLE`: on `preamble_valid & control`, load `data` as DST byte 0, set `cnt`=1, go to `DST`.
- `DST`: shift `data` in while `cnt`<6.
  - `cnt`==6 with `dst_addr_valid` high: load SRC byte 0, set `cnt`=1, go to `SRC`.
  - `cnt`==6 without the pulse, or the pulse with `cnt`≠6: go to `ABORT`.
- `SRC`: same rule as `DST`, keyed on `src_addr_valid`; on success go to `TL`.
- `TL`: two bytes, keyed on `type_length_valid` once `cnt`==2; on success go to `WAIT`. Payload bytes are ignored.
- `WAIT`: on `packet_size_valid`, push {dst, src, tl} and go to `IDLE`.
- `ABORT`: one cycle, then `IDLE`.

Abort and restart rules:
- `control` low in `DST`/`SRC`/`TL`/`WAIT` aborts the frame; no push.
- `packet_size_valid` and `control` low on the same edge in `WAIT`: the push wins.
- `preamble_valid` in any state other than `IDLE`: the current frame is aborted and a new capture starts on that edge (state `DST`, `cnt`=1).

FIFO behaviour:
- Push when full: the record is dropped. Exception: a pop occurs on the same edge, in which case the push is accepted.
- Pop occurs when `hdr_valid & hdr_ready`.
- Pointers are log2(DEPTH)+1 bits wide and wrap naturally.

## Timing
- Reset values: `hdr_valid`=0; `hdr_dst`, `hdr_src`, `hdr_type_length`=0; FSM in `IDLE`; FIFO empty; counters 0.
- Latency: `hdr_valid` rises on the edge after the push edge.
- Head fields are stable while `hdr_valid` is high and no pop occurs.
- When `hdr_valid`=0, the `hdr_*` fields are don't-care after the first push.
- `hdr_valid` must not depend combinationally on `hdr_ready`.
- Full throughput: one push and one pop per cycle.
- `reset_n` asserted mid-frame or mid-drain clears everything immediately. No partial record is ever pushed.

## Configuration
- Macro `EPD_HDR_STATS_EN`. When defined, two extra output ports are added:
  - `abort_count`  out  8: saturating count of `ABORT` entries and restarts.
  - `drop_count`  out  8: saturating count of pushes lost to a full FIFO.
  - Both reset to 0 and saturate at 8'hFF.
- When the macro is undefined, both ports and their counters are absent; functional behaviour is otherwise identical.

## Structure
- Shared package `epd_pkg` holds:
  - the FSM state encoding (`IDLE`, `DST`, `SRC`, `TL`, `WAIT`, `ABORT`);
  - field widths: `EPD_MAC_W`=48, `EPD_TL_W`=16;
  - byte counts: `EPD_MAC_BYTES`=6, `EPD_TL_BYTES`=2;
  - the record width `EPD_HDR_W`=112.
- One sub-module, `epd_hdr_fifo`: a synchronous FIFO of `EPD_HDR_W` × `DEPTH` with push/pop, full/empty and registered head.

## Test plan
- **Nominal frame.** Preamble; DST 01..06; SRC FF..FA; TL 08 00; 50 payload bytes; then `packet_size_valid`. Expect `hdr_valid` one cycle later with `hdr_dst`=48'h010203040506, `hdr_src`=48'hFFFEFDFCFBFA, `hdr_type_length`=16'h0800.
- **Misaligned pulse.** `dst_addr_valid` pulsed after DST byte 4 (`cnt`=5). Expect no push; `abort_count`=1; a following nominal frame is captured correctly.
- **Control drop.** `control` goes low in `WAIT` before `packet_size_valid`. Expect no push. Then `packet_size_valid` and `control` low on the same edge: expect one push.
- **FIFO full.** `hdr_ready`=0 and DEPTH+1 frames sent. Expect exactly DEPTH records and `drop_count`=1. Then drain with `hdr_ready`=1: records come out in order and `hdr_valid` falls after the DEPTHth pop.
- **Push and pop at full.** A push coincides with a pop while the FIFO is full. Expect the push accepted and `drop_count` unchanged.
- **Reset mid-frame.** `reset_n` low during SRC byte 3. Expect all outputs at reset values and FIFO empty; the next full frame is captured normally.
